// File: rtl/evlog_pkg.sv
// Shared defaults and record layout for the change event logger.
// The timestamp field is present only when EVLOG_TIMESTAMP_EN is defined.
package evlog_pkg;
  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 8;
  localparam int TSW_DEF   = 16;

  localparam logic [7:0] DROP_SAT = 8'hFF;

  // Record layout: {data, ts}; ts sits in the low bits when stored.
  localparam int REC_TS_LSB = 0;
endpackage

// File: rtl/evlog_fifo.sv
// Synchronous show-ahead FIFO; dout shows the head and reads 0 while empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module evlog_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + (AW+1)'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - (AW+1)'(1);
    end
  end

  // Storage is not reset; the empty mask on dout hides stale entries.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = empty ? '0 : r_mem[r_rd_ptr];
  assign count = r_count;
endmodule

// File: rtl/change_event_logger.sv
// Logs every clock-edge value change of sig_in as a {value, timestamp} record into a FIFO,
// with sticky overflow and saturating drop count. EVLOG_TIMESTAMP_EN enables the timestamp.
module change_event_logger
  import evlog_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int TSW   = TSW_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [DW-1:0]          sig_in,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [DW-1:0]          evt_data,
  output logic [TSW-1:0]         evt_ts,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [7:0]             drop_cnt,
  input  logic                   clr_ovf
);
`ifdef EVLOG_TIMESTAMP_EN
  localparam int RW   = DW + TSW;
  localparam int DLSB = TSW;
`else
  localparam int RW   = DW;
  localparam int DLSB = 0;
`endif

  logic [DW-1:0] r_prev;
  logic          r_primed;
  logic          r_ovf;
  logic [7:0]    r_drop;
  logic [RW-1:0] w_din;
  logic [RW-1:0] w_dout;
  logic          w_change;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_drop;

  // Handshake: a record transfers on any edge where evt_valid & evt_ready; the head
  // holds steady while evt_valid & !evt_ready, and valid never depends on ready.
  assign w_change  = r_primed & (sig_in != r_prev);
  assign w_push    = w_change & en;
  assign evt_valid = ~w_empty;
  assign w_pop     = evt_valid & evt_ready;
  assign w_drop    = w_push & w_full & ~w_pop;

`ifdef EVLOG_TIMESTAMP_EN
  logic [TSW-1:0] r_ts;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ts <= '0;
    else     r_ts <= r_ts + TSW'(1);
  end

  assign w_din  = {sig_in, r_ts};
  assign evt_ts = w_dout[REC_TS_LSB +: TSW];
`else
  assign w_din  = sig_in;
  assign evt_ts = '0;
`endif

  assign evt_data = w_dout[DLSB +: DW];

  // prev tracks even while disabled so re-enabling never logs a stale difference.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev   <= '0;
      r_primed <= 1'b0;
      r_ovf    <= 1'b0;
      r_drop   <= '0;
    end else begin
      r_prev   <= sig_in;
      r_primed <= 1'b1;
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (clr_ovf)                r_drop <= 8'd1;
        else if (r_drop != DROP_SAT) r_drop <= r_drop + 8'd1;
      end else if (clr_ovf) begin
        r_ovf  <= 1'b0;
        r_drop <= '0;
      end
    end
  end

  assign overflow = r_ovf;
  assign drop_cnt = r_drop;

  evlog_fifo #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_dout),
    .count (count),
    .full  (w_full),
    .empty (w_empty)
  );
endmodule
